// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous RAM port between CPU, VGA and button mirror.
// Ports: cpu_* (load/store), vga_* (pixel reads), btn_data, mem_* (RAM side).
module mem_arbiter #(
  parameter int unsigned VGA_MAX_WAIT = 4,
  parameter logic [31:0] BTN_ADDR = 32'h0000_1FFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_sel,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_stall,
  input  logic        vga_req,
  input  logic [31:0] vga_addr,
  output logic [31:0] vga_rdata,
  output logic        vga_valid,
  input  logic [31:0] btn_data,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDATA} state_e;
  typedef enum logic [1:0] {O_CPU, O_VGA, O_BTN} owner_e;

  localparam logic [3:0] WAIT_MAX = 4'(VGA_MAX_WAIT);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        cool_q, cool_d;
  logic [3:0]  vga_wait_q, vga_wait_d;
  logic        btn_pend_q, btn_pend_d;
  logic [31:0] btn_last_q, btn_last_d;
  logic [31:0] btn_shadow_q, btn_shadow_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_sel_q, mem_sel_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic        cpu_done_q, cpu_done_d;
  logic [31:0] vga_rdata_q, vga_rdata_d;
  logic        vga_valid_q, vga_valid_d;

  logic gnt_cpu, gnt_vga, gnt_btn, gnt_any;
  logic wr_end, rd_end, btn_done, btn_busy, vga_owns;

  // The IDLE cycle that carries a completion pulse does not arbitrate,
  // so a requester still holding its request cannot be served twice.
  always_comb begin
    gnt_cpu = 1'b0;
    gnt_vga = 1'b0;
    gnt_btn = 1'b0;
    if (state_q == S_IDLE && !cool_q) begin
      if (vga_req && vga_wait_q == WAIT_MAX) gnt_vga = 1'b1;
      else if (cpu_req)                     gnt_cpu = 1'b1;
      else if (vga_req)                     gnt_vga = 1'b1;
      else if (btn_pend_q)                  gnt_btn = 1'b1;
    end
  end

  assign gnt_any  = gnt_cpu | gnt_vga | gnt_btn;
  assign wr_end   = (state_q == S_ISSUE) && mem_we_q;
  assign rd_end   = (state_q == S_RDATA);
  assign btn_done = wr_end && (owner_q == O_BTN);
  assign vga_owns = (state_q != S_IDLE) && (owner_q == O_VGA);
  assign btn_busy = gnt_btn
                  | ((state_q != S_IDLE) && (owner_q == O_BTN));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= O_CPU;
      cool_q       <= 1'b0;
      vga_wait_q   <= '0;
      btn_pend_q   <= 1'b0;
      btn_last_q   <= '0;
      btn_shadow_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_sel_q    <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      cpu_done_q   <= 1'b0;
      vga_rdata_q  <= '0;
      vga_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cool_q       <= cool_d;
      vga_wait_q   <= vga_wait_d;
      btn_pend_q   <= btn_pend_d;
      btn_last_q   <= btn_last_d;
      btn_shadow_q <= btn_shadow_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_sel_q    <= mem_sel_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_done_q   <= cpu_done_d;
      vga_rdata_q  <= vga_rdata_d;
      vga_valid_q  <= vga_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) state_d = S_ISSUE;
        if (gnt_cpu) owner_d = O_CPU;
        if (gnt_vga) owner_d = O_VGA;
        if (gnt_btn) owner_d = O_BTN;
      end
      S_ISSUE: state_d = mem_we_q ? S_IDLE : S_RDATA;
      S_RDATA: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cool_d      = wr_end | rd_end;
    mem_en_d    = gnt_any;
    mem_we_d    = (gnt_cpu & cpu_we) | gnt_btn;
    mem_sel_d   = '0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (gnt_cpu) begin
      mem_sel_d   = cpu_sel;
      mem_addr_d  = cpu_addr;
      mem_wdata_d = cpu_wdata;
    end
    if (gnt_vga) begin
      mem_sel_d  = 4'hF;
      mem_addr_d = vga_addr;
    end
    if (gnt_btn) begin
      mem_sel_d   = 4'hF;
      mem_addr_d  = BTN_ADDR;
      mem_wdata_d = btn_shadow_q;
    end

    cpu_done_d  = (wr_end | rd_end) && (owner_q == O_CPU);
    vga_valid_d = rd_end && (owner_q == O_VGA);
    cpu_rdata_d = cpu_rdata_q;
    vga_rdata_d = vga_rdata_q;
    if (rd_end && owner_q == O_CPU) cpu_rdata_d = mem_rdata;
    if (rd_end && owner_q == O_VGA) vga_rdata_d = mem_rdata;

    vga_wait_d = vga_wait_q;
    if (!vga_req || gnt_vga) vga_wait_d = '0;
    else if (!vga_owns && vga_wait_q < WAIT_MAX)
      vga_wait_d = vga_wait_q + 4'd1;

    // Shadow is frozen from grant to completion so the value recorded
    // as written is exactly the one latched into mem_wdata.
    btn_pend_d   = btn_pend_q;
    btn_last_d   = btn_last_q;
    btn_shadow_d = btn_shadow_q;
    if (btn_done) begin
      btn_last_d = btn_shadow_q;
      btn_pend_d = 1'b0;
    end else if (!btn_busy && btn_data != btn_last_q) begin
      btn_pend_d   = 1'b1;
      btn_shadow_d = btn_data;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_sel   = mem_sel_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_done  = cpu_done_q;
  assign cpu_stall = cpu_req & ~cpu_done_q;
  assign vga_rdata = vga_rdata_q;
  assign vga_valid = vga_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter with a small RAM model.
// Drives requests after each rising edge and samples 1ns later.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_sel;
  logic        cpu_done, cpu_stall;
  logic        vga_req;
  logic [31:0] vga_addr, vga_rdata;
  logic        vga_valid;
  logic [31:0] btn_data;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] mem_rdata = '0;

  logic        ram_init;
  logic [31:0] ram [0:2047];

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.VGA_MAX_WAIT(4), .BTN_ADDR(32'h0000_1FFC)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_sel(cpu_sel), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vga_rdata),
    .vga_valid(vga_valid), .btn_data(btn_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_sel(mem_sel), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 2048; i++) ram[i] <= '0;
      ram[128] <= 32'hCAFE_0001;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_sel[b])
            ram[mem_addr[12:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[12:2]];
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic prev_pulse = 1'b0;
  always @(negedge clk) begin
    if (!rst && (cpu_done || vga_valid)) begin
      chk("pulse_excl", 32'(cpu_done & vga_valid), 0);
      chk("pulse_repeat", 32'(prev_pulse), 0);
    end
    prev_pulse = cpu_done | vga_valid;
  end

  int          ens, ndone, vga_iss, vga_vcyc, cpu_iss2, nlog;
  int          log_cyc [4];
  logic [31:0] log_addr [4];

  initial begin
    rst = 1'b1; ram_init = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_sel = '0;
    cpu_wdata = '0; vga_req = 0; vga_addr = '0; btn_data = '0;
    step(); step();
    ram_init = 1'b0;

    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_sel", 32'(mem_sel), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_done", 32'(cpu_done), 0);
    chk("rst_vga_valid", 32'(vga_valid), 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_vga_rdata", vga_rdata, 0);
    chk("rst_stall0", 32'(cpu_stall), 0);
    cpu_req = 1; #1;
    chk("rst_stall1", 32'(cpu_stall), 1);
    cpu_req = 0;
    rst = 1'b0;

    ens = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_en || cpu_done || vga_valid) ens++;
    end
    chk("quiet_activity", ens, 0);

    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10;
    cpu_sel = 4'b0011; cpu_wdata = 32'hDEAD_BEEF;
    #1 chk("wr_stall", 32'(cpu_stall), 1);
    step();
    chk("wr_mem_en", 32'(mem_en), 1);
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_addr", mem_addr, 32'h10);
    chk("wr_mem_sel", 32'(mem_sel), 32'h3);
    chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("wr_done_early", 32'(cpu_done), 0);
    step();
    chk("wr_done", 32'(cpu_done), 1);
    chk("wr_stall_off", 32'(cpu_stall), 0);
    chk("wr_en_off", 32'(mem_en), 0);
    chk("wr_sel_off", 32'(mem_sel), 0);
    cpu_req = 0;
    step();
    chk("wr_done_once", 32'(cpu_done), 0);

    cpu_req = 1; cpu_we = 0; cpu_sel = 4'hF;
    step();
    chk("rd_mem_en", 32'(mem_en), 1);
    chk("rd_mem_we", 32'(mem_we), 0);
    step();
    chk("rd_done_early", 32'(cpu_done), 0);
    chk("rd_en_off", 32'(mem_en), 0);
    step();
    chk("rd_done", 32'(cpu_done), 1);
    chk("rd_data", cpu_rdata, 32'h0000_BEEF);
    cpu_req = 0;
    step();

    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20; cpu_sel = 4'hF;
    vga_req = 1; vga_addr = 32'h200;
    vga_iss = -1; vga_vcyc = -1; cpu_iss2 = -1; ndone = 0;
    for (int i = 1; i <= 11; i++) begin
      step();
      if (mem_en && mem_addr == 32'h200 && vga_iss < 0) begin
        vga_iss = i;
        chk("vga_we", 32'(mem_we), 0);
        chk("vga_sel", 32'(mem_sel), 32'hF);
      end
      if (mem_en && mem_addr == 32'h20 && i > 7 && cpu_iss2 < 0)
        cpu_iss2 = i;
      if (vga_valid) begin
        vga_vcyc = i;
        vga_req = 0;
      end
      if (cpu_done) ndone++;
      if (i == 11) cpu_req = 0;
    end
    chk("starve_vga_issue", vga_iss, 5);
    chk("starve_vga_valid", vga_vcyc, 7);
    chk("starve_vga_rdata", vga_rdata, 32'hCAFE_0001);
    chk("starve_cpu_resume", cpu_iss2, 9);
    chk("starve_cpu_dones", ndone, 2);
    chk("starve_cpu_rdata", cpu_rdata, 0);
    step();
    chk("starve_no_regrant", 32'(mem_en), 0);

    btn_data = 32'h5;
    step();
    chk("btn1_wait", 32'(mem_en), 0);
    step();
    chk("btn1_en", 32'(mem_en), 1);
    chk("btn1_we", 32'(mem_we), 1);
    chk("btn1_addr", mem_addr, 32'h1FFC);
    chk("btn1_wdata", mem_wdata, 32'h5);
    chk("btn1_sel", 32'(mem_sel), 32'hF);
    btn_data = 32'h7;
    step();
    chk("btn_gap1", 32'(mem_en), 0);
    step();
    chk("btn_gap2", 32'(mem_en), 0);
    step();
    chk("btn2_en", 32'(mem_en), 1);
    chk("btn2_addr", mem_addr, 32'h1FFC);
    chk("btn2_wdata", mem_wdata, 32'h7);
    ens = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mem_en) ens++;
    end
    chk("btn_no_extra", ens, 0);
    chk("btn_ram", ram[2047], 32'h7);

    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; cpu_sel = 4'hF;
    step();
    chk("rst_rd_issue", 32'(mem_en), 1);
    rst = 1; btn_data = '0;
    step();
    chk("rst_abort_en", 32'(mem_en), 0);
    chk("rst_abort_done", 32'(cpu_done), 0);
    chk("rst_abort_rdata", cpu_rdata, 0);
    chk("rst_abort_stall", 32'(cpu_stall), 1);
    rst = 0;
    step();
    chk("rst_reissue_en", 32'(mem_en), 1);
    chk("rst_reissue_addr", mem_addr, 32'h10);
    step();
    chk("rst_reissue_early", 32'(cpu_done), 0);
    step();
    chk("rst_reissue_done", 32'(cpu_done), 1);
    chk("rst_reissue_data", cpu_rdata, 32'h0000_BEEF);
    cpu_req = 0;
    step();

    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30;
    cpu_sel = 4'hF; cpu_wdata = 32'h11;
    vga_req = 1; vga_addr = 32'h200; btn_data = 32'h9;
    nlog = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (mem_en && nlog < 4) begin
        log_cyc[nlog]  = i;
        log_addr[nlog] = mem_addr;
        nlog++;
      end
      if (cpu_done) cpu_req = 0;
      if (vga_valid) vga_req = 0;
    end
    chk("order_count", nlog, 3);
    chk("order_cpu_addr", log_addr[0], 32'h30);
    chk("order_cpu_cyc", log_cyc[0], 1);
    chk("order_vga_addr", log_addr[1], 32'h200);
    chk("order_vga_cyc", log_cyc[1], 4);
    chk("order_btn_addr", log_addr[2], 32'h1FFC);
    chk("order_btn_cyc", log_cyc[2], 8);
    chk("order_btn_ram", ram[2047], 32'h9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
